// File: rtl/gray_ser_pkg.sv
// Shared types and helpers for the Gray-code counter serializer.
// GRAY_SER_PARITY_EN appends an even-parity bit to every frame.
package gray_ser_pkg;

  typedef enum logic [1:0] {
    ST_COUNT     = 2'd0,
    ST_LOAD      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

`ifdef GRAY_SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // marker + payload (+ parity)
  function automatic int frame_len(input int width);
    return width + 1 + PAR_BITS;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_shift_tx.sv
// Serial frame transmitter: marker, Gray MSB..LSB, optional parity.
// GRAY_SER_PARITY_EN adds the trailing even-parity bit.
module gray_shift_tx
  import gray_ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             load,
  input  logic             shift,
  input  logic             abort,
  input  logic [WIDTH-1:0] gray,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             frame_sent,
  output logic             last_bit
);

  localparam int FL = frame_len(WIDTH);
  localparam int CW = $clog2(FL);
  localparam logic [CW-1:0] CNT_INIT = CW'(FL - 1);

  logic [FL-1:0] shift_reg;
  logic [FL-1:0] frame;
  logic [CW-1:0] bit_cnt;

`ifdef GRAY_SER_PARITY_EN
  assign frame = {1'b1, gray, ^gray};
`else
  assign frame = {1'b1, gray};
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ser_data   <= 1'b0;
      ser_valid  <= 1'b0;
      frame_sent <= 1'b0;
      last_bit   <= 1'b0;
    end else begin
      frame_sent <= 1'b0;
      if (abort) begin
        bit_cnt   <= '0;
        ser_data  <= 1'b0;
        ser_valid <= 1'b0;
        last_bit  <= 1'b0;
      end else if (load) begin
        shift_reg <= frame;
        bit_cnt   <= CNT_INIT;
        ser_data  <= 1'b0;
        ser_valid <= 1'b0;
        last_bit  <= 1'b0;
      end else if (shift) begin
        if (last_bit) begin
          ser_data   <= 1'b0;
          ser_valid  <= 1'b0;
          frame_sent <= 1'b1;
          last_bit   <= 1'b0;
        end else begin
          ser_data  <= shift_reg[FL-1];
          ser_valid <= 1'b1;
          shift_reg <= {shift_reg[FL-2:0], 1'b0};
          // bit_cnt==0 marks the final emitted bit
          if (bit_cnt == '0) last_bit <= 1'b1;
          else bit_cnt <= bit_cnt - 1'b1;
        end
      end else begin
        ser_data  <= 1'b0;
        ser_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gray_cnt_serializer.sv
// Saturating counter that freezes and ships its Gray code serially.
// GRAY_SER_PARITY_EN selects frames with a trailing parity bit.
module gray_cnt_serializer
  import gray_ser_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] STEP    = 1,
  parameter logic [WIDTH-1:0] SAT_MAX = '1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             en_handshake,
  input  logic             b_done,
  output logic [WIDTH-1:0] cnt_bin,
  output logic             a_clk_en,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             frame_sent
);

  state_t           state;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] gray;
  logic             tx_load;
  logic             tx_shift;
  logic             tx_abort;
  logic             last_bit;

  // WIDTH+1 bit sum so the ceiling compare never wraps
  assign sum      = {1'b0, cnt_bin} + {1'b0, STEP};
  assign cnt_next = (sum > {1'b0, SAT_MAX}) ? SAT_MAX : sum[WIDTH-1:0];
  assign gray     = WIDTH'(bin2gray(32'(cnt_bin)));

  assign tx_load  = (state == ST_LOAD);
  assign tx_shift = (state == ST_SHIFT);
  assign tx_abort = b_done && (tx_load || tx_shift);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_COUNT;
      cnt_bin  <= '0;
      a_clk_en <= 1'b1;
    end else begin
      unique case (state)
        ST_COUNT: begin
          if (en_handshake) begin
            a_clk_en <= 1'b0;
            state    <= ST_LOAD;
          end else begin
            cnt_bin <= cnt_next;
          end
        end
        ST_LOAD, ST_SHIFT, ST_WAIT_DONE: begin
          if (b_done) begin
            cnt_bin  <= '0;
            a_clk_en <= 1'b1;
            state    <= ST_COUNT;
          end else if (state == ST_LOAD) begin
            state <= ST_SHIFT;
          end else if (state == ST_SHIFT && last_bit) begin
            state <= ST_WAIT_DONE;
          end
        end
        default: state <= ST_COUNT;
      endcase
    end
  end

  gray_shift_tx #(
    .WIDTH(WIDTH)
  ) u_tx (
    .clk       (clk),
    .reset_b   (reset_b),
    .load      (tx_load),
    .shift     (tx_shift),
    .abort     (tx_abort),
    .gray      (gray),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .frame_sent(frame_sent),
    .last_bit  (last_bit)
  );

endmodule

// File: tb/tb_gray_cnt_serializer.sv
// Directed bench for gray_cnt_serializer (STEP=1, 3 and 100 instances).
// Define GRAY_SER_PARITY_EN to expect parity-extended frames.
module tb_gray_cnt_serializer;

`ifdef GRAY_SER_PARITY_EN
  localparam int FL = 10;
`else
  localparam int FL = 9;
`endif

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  logic en_handshake = 1'b0;
  logic b_done = 1'b0;

  logic [7:0] c1, c3, c100;
  logic a1, a3, a100;
  logic d1, d3, d100;
  logic v1, v3, v100;
  logic f1, f3, f100;

  int pass_cnt = 0;
  int total = 0;
  logic [9:0] exp_frame;
  int exp100 [5] = '{100, 200, 255, 255, 255};

  always #5 clk = ~clk;

  gray_cnt_serializer #(.WIDTH(8), .STEP(8'd1)) u1 (
    .clk(clk), .reset_b(reset_b), .en_handshake(en_handshake),
    .b_done(b_done), .cnt_bin(c1), .a_clk_en(a1),
    .ser_data(d1), .ser_valid(v1), .frame_sent(f1));

  gray_cnt_serializer #(.WIDTH(8), .STEP(8'd3)) u3 (
    .clk(clk), .reset_b(reset_b), .en_handshake(en_handshake),
    .b_done(b_done), .cnt_bin(c3), .a_clk_en(a3),
    .ser_data(d3), .ser_valid(v3), .frame_sent(f3));

  gray_cnt_serializer #(.WIDTH(8), .STEP(8'd100)) u100 (
    .clk(clk), .reset_b(reset_b), .en_handshake(en_handshake),
    .b_done(b_done), .cnt_bin(c100), .a_clk_en(a100),
    .ser_data(d100), .ser_valid(v100), .frame_sent(f100));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
`ifdef GRAY_SER_PARITY_EN
    exp_frame = 10'b1_0000_0111_1;
`else
    exp_frame = 10'b0_1000_0011_1;
`endif
    #1 reset_b = 1'b0;
    step();
    step();
    chk("rst_cnt", 32'(c1), 0);
    chk("rst_clk_en", 32'(a1), 1);
    chk("rst_valid", 32'(v1), 0);
    chk("rst_data", 32'(d1), 0);
    chk("rst_sent", 32'(f1), 0);
    reset_b = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("cnt3_%0d", i), 32'(c3), 32'(3 * i));
      chk($sformatf("sat100_%0d", i), 32'(c100), 32'(exp100[i-1]));
      chk($sformatf("clk_en_%0d", i), 32'(a3), 1);
      chk($sformatf("valid_idle_%0d", i), 32'(v3), 0);
    end
    chk("cnt1_at5", 32'(c1), 5);

    en_handshake = 1'b1;
    step();
    en_handshake = 1'b0;
    chk("freeze_clk_en", 32'(a1), 0);
    chk("freeze_cnt", 32'(c1), 5);
    step();
    chk("load_valid", 32'(v1), 0);
    for (int k = 0; k < FL; k++) begin
      step();
      chk($sformatf("frm_valid_%0d", k), 32'(v1), 1);
      chk($sformatf("frm_bit_%0d", k), 32'(d1), 32'(exp_frame[FL-1-k]));
      chk($sformatf("frm_nosent_%0d", k), 32'(f1), 0);
    end
    step();
    chk("end_valid", 32'(v1), 0);
    chk("end_data", 32'(d1), 0);
    chk("sent_pulse", 32'(f1), 1);
    step();
    chk("sent_one_cycle", 32'(f1), 0);
    chk("wait_valid", 32'(v1), 0);
    chk("wait_cnt", 32'(c1), 5);
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    chk("done_cnt", 32'(c1), 0);
    chk("done_clk_en", 32'(a1), 1);
    step();
    chk("resume_cnt", 32'(c1), 1);

    en_handshake = 1'b1;
    step();
    en_handshake = 1'b0;
    step();
    for (int k = 0; k < 3; k++) step();
    chk("abort_pre_valid", 32'(v1), 1);
    b_done = 1'b1;
    step();
    b_done = 1'b0;
    chk("abort_valid", 32'(v1), 0);
    chk("abort_data", 32'(d1), 0);
    chk("abort_cnt", 32'(c1), 0);
    chk("abort_clk_en", 32'(a1), 1);
    chk("abort_nosent", 32'(f1), 0);
    step();
    chk("abort_count", 32'(c1), 1);
    chk("abort_nosent2", 32'(f1), 0);

    en_handshake = 1'b1;
    step();
    en_handshake = 1'b0;
    step();
    step();
    chk("mid_valid", 32'(v1), 1);
    chk("mid_marker", 32'(d1), 1);
    #2 reset_b = 1'b0;
    #1;
    chk("async_cnt", 32'(c1), 0);
    chk("async_clk_en", 32'(a1), 1);
    chk("async_valid", 32'(v1), 0);
    chk("async_data", 32'(d1), 0);
    @(negedge clk);
    reset_b = 1'b1;
    step();
    chk("restart_1", 32'(c1), 1);
    step();
    chk("restart_2", 32'(c1), 2);
    chk("restart_valid", 32'(v1), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
